// File: rtl/fpu_operand_decoder.sv
// FPU operand decode stage: latches two IEEE-754 singles,
// classifies them and normalises subnormals one bit per cycle.
module fpu_operand_decoder #(
  parameter int EXP_W = 10,
  parameter int MAN_W = 24
) (
  input  logic             fpu_clk,
  input  logic             fpu_rst_n,
  input  logic             fpu_dec_en_i,
  input  logic [31:0]      fpu_opa_i,
  input  logic [31:0]      fpu_opb_i,
  output logic             fpu_dec_ready_o,
  output logic             fpu_sign_a_o,
  output logic             fpu_sign_b_o,
  output logic [EXP_W-1:0] fpu_exp_a_o,
  output logic [EXP_W-1:0] fpu_exp_b_o,
  output logic [MAN_W-1:0] fpu_man_a_o,
  output logic [MAN_W-1:0] fpu_man_b_o,
  output logic [4:0]       fpu_class_a_o,
  output logic [4:0]       fpu_class_b_o
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    READY
  } state_t;

  // class bits: {snan, qnan, inf, zero, subnormal}
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [4:0]       c;
  } op_t;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = EXP_W'(128);
  localparam logic [EXP_W-1:0] EXP_SUB     = EXP_W'(-126);
  localparam logic [EXP_W-1:0] EXP_BIAS    = EXP_W'(127);

  function automatic op_t unpack(input logic [31:0] x);
    op_t        r;
    logic [7:0] ef;
    logic [22:0] ff;
    logic       e_max;
    logic       e_min;
    logic       f_nz;
    ef    = x[30:23];
    ff    = x[22:0];
    e_max = (ef == 8'hFF);
    e_min = (ef == 8'h00);
    f_nz  = |ff;
    r.s   = x[31];
    r.e   = '0;
    r.m   = '0;
    r.c   = '0;
    unique case (1'b1)
      (e_max && !f_nz): begin
        r.e = EXP_SPECIAL;
        r.m = MAN_W'(ff);
        r.c = 5'b00100;
      end
      (e_max && f_nz && ff[22]): begin
        r.e = EXP_SPECIAL;
        r.m = MAN_W'(ff);
        r.c = 5'b01000;
      end
      (e_max && f_nz && !ff[22]): begin
        r.e = EXP_SPECIAL;
        r.m = MAN_W'(ff);
        r.c = 5'b10000;
      end
      (e_min && !f_nz): begin
        r.c = 5'b00010;
      end
      (e_min && f_nz): begin
        r.e = EXP_SUB;
        r.m = MAN_W'(ff);
        r.c = 5'b00001;
      end
      default: begin
        r.e = EXP_W'(ef) - EXP_BIAS;
        r.m = MAN_W'({1'b1, ff});
      end
    endcase
    return r;
  endfunction

  function automatic logic needs_shift(input op_t o);
    return o.c[0] && !o.m[MAN_W-1];
  endfunction

  function automatic op_t step(input op_t o);
    op_t r;
    r = o;
    if (needs_shift(o)) begin
      r.m = o.m << 1;
      r.e = o.e - EXP_W'(1);
    end
    return r;
  endfunction

  state_t state_q, state_d;
  op_t    a_q, a_d;
  op_t    b_q, b_d;
  logic   ready_q, ready_d;

  // next-state: capture in IDLE, shift in NORM, hold in READY
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (!fpu_dec_en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          a_d     = unpack(fpu_opa_i);
          b_d     = unpack(fpu_opb_i);
          state_d = NORM;
        end
        NORM: begin
          if (needs_shift(a_q) || needs_shift(b_q)) begin
            a_d = step(a_q);
            b_d = step(b_q);
          end else begin
            state_d = READY;
          end
        end
        READY: state_d = READY;
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == READY);
  end

  // state and decoded-operand registers
  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ready_q <= ready_d;
    end
  end

  assign fpu_dec_ready_o = ready_q;
  assign fpu_sign_a_o    = a_q.s;
  assign fpu_sign_b_o    = b_q.s;
  assign fpu_exp_a_o     = a_q.e;
  assign fpu_exp_b_o     = b_q.e;
  assign fpu_man_a_o     = a_q.m;
  assign fpu_man_b_o     = b_q.m;
  assign fpu_class_a_o   = a_q.c;
  assign fpu_class_b_o   = b_q.c;

endmodule
